// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port strobe/ack arbiter onto one combinational-read memory port.
// Define MEM_ARB_RR_EN for round-robin contention; otherwise port 0 has fixed priority.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p0_stb,
    input  logic [19:0] p0_addr,
    input  logic        p0_we,
    input  logic        p0_byte,
    input  logic [15:0] p0_wdata,
    output logic        p0_ack,
    output logic [15:0] p0_rdata,
    input  logic        p1_stb,
    input  logic [19:0] p1_addr,
    input  logic        p1_we,
    input  logic        p1_byte,
    input  logic [15:0] p1_wdata,
    output logic        p1_ack,
    output logic [15:0] p1_rdata,
    output logic [19:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        mem_we,
    output logic        mem_byte
);
    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
    state_t state;
    logic   grant;
    logic   win;
`ifdef MEM_ARB_RR_EN
    logic   last;
    // on contention the port not served last time wins
    assign win = (p0_stb && p1_stb) ? ~last : ~p0_stb;
`else
    assign win = ~p0_stb;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last      <= 1'b1;
`endif
            p0_ack    <= 1'b0;
            p1_ack    <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_byte  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (p0_stb || p1_stb) begin
                    grant     <= win;
`ifdef MEM_ARB_RR_EN
                    last      <= win;
`endif
                    mem_addr  <= win ? p1_addr  : p0_addr;
                    mem_wdata <= win ? p1_wdata : p0_wdata;
                    mem_we    <= win ? p1_we    : p0_we;
                    mem_byte  <= win ? p1_byte  : p0_byte;
                    state     <= BUSY;
                end
                BUSY: begin
                    if (!mem_we && grant) p1_rdata <= mem_rdata;
                    if (!mem_we && !grant) p0_rdata <= mem_rdata;
                    p0_ack <= ~grant;
                    p1_ack <= grant;
                    mem_we <= 1'b0;
                    state  <= ACK;
                end
                ACK: begin
                    p0_ack <= 1'b0;
                    p1_ack <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector bench for mem_arbiter with a little-endian byte memory.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p0_stb = 0, p1_stb = 0;
    logic [19:0] p0_addr = 0, p1_addr = 0;
    logic        p0_we = 0, p1_we = 0, p0_byte = 0, p1_byte = 0;
    logic [15:0] p0_wdata = 0, p1_wdata = 0;
    logic        p0_ack, p1_ack;
    logic [15:0] p0_rdata, p1_rdata;
    logic [19:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_we, mem_byte;
    logic [7:0]  mem [0:1048575];
    logic [19:0] addr_nx;
    int checks = 0, errors = 0;
    logic [15:0] lr [2];

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .p0_stb(p0_stb), .p0_addr(p0_addr), .p0_we(p0_we), .p0_byte(p0_byte),
        .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_stb(p1_stb), .p1_addr(p1_addr), .p1_we(p1_we), .p1_byte(p1_byte),
        .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_byte(mem_byte)
    );

    always #5 clk = ~clk;

    assign addr_nx = mem_addr + 20'd1;
    assign mem_rdata = mem_byte ? {{8{mem[mem_addr][7]}}, mem[mem_addr]} : {mem[addr_nx], mem[mem_addr]};
    always @(posedge clk) if (mem_we) begin
        mem[mem_addr] <= mem_wdata[7:0];
        if (!mem_byte) mem[addr_nx] <= mem_wdata[15:8];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic ack_of(input bit port);
        return port ? p1_ack : p0_ack;
    endfunction

    task automatic drive(input bit port, input bit stb, input bit we, input bit bm,
                         input logic [19:0] a, input logic [15:0] wd);
        if (port) begin
            p1_stb = stb; p1_we = we; p1_byte = bm; p1_addr = a; p1_wdata = wd;
        end else begin
            p0_stb = stb; p0_we = we; p0_byte = bm; p0_addr = a; p0_wdata = wd;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        chk(name, {p0_ack, p1_ack, p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_we, mem_byte}, 64'd0);
    endtask

    // one access: strobe raised at a negedge, ack expected two sampling edges later
    task automatic access(input bit port, input bit we, input bit bm, input logic [19:0] a,
                          input logic [15:0] wd, input logic [15:0] rd);
        int n = 0;
        @(negedge clk);
        drive(port, 1'b1, we, bm, a, wd);
        for (int i = 1; i <= 6 && n == 0; i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk("busy_we", mem_we, we);
                chk("busy_addr", mem_addr, a);
                chk("busy_byte", mem_byte, bm);
                if (we) chk("busy_wdata", mem_wdata, wd);
            end
            if (ack_of(port)) n = i;
        end
        chk("ack_latency", n, 2);
        if (!we) lr[port] = rd;
        chk("rdata", port ? p1_rdata : p0_rdata, lr[port]);
        chk("ack_we_low", mem_we, 1'b0);
        chk("other_ack", ack_of(~port), 1'b0);
        drive(port, 1'b0, we, bm, a, wd);
        @(negedge clk);
        chk("ack_cleared", ack_of(port), 1'b0);
        chk("addr_held", mem_addr, a);
    endtask

    typedef struct {
        bit          port;
        bit          we;
        bit          bm;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } vec_t;

    vec_t vecs [9];
    int   nacc, gcnt;
    bit   g [6];

    initial begin
        vecs[0] = '{0, 1, 0, 20'h00100, 16'hBEEF, 16'h0000};
        vecs[1] = '{0, 0, 0, 20'h00100, 16'h0000, 16'hBEEF};
        vecs[2] = '{1, 1, 0, 20'h00200, 16'h0000, 16'h0000};
        vecs[3] = '{1, 1, 1, 20'h00201, 16'h0080, 16'h0000};
        vecs[4] = '{1, 0, 1, 20'h00201, 16'h0000, 16'hFF80};
        vecs[5] = '{1, 0, 0, 20'h00200, 16'h0000, 16'h8000};
        vecs[6] = '{0, 1, 0, 20'hFFFFF, 16'h1234, 16'h0000};
        vecs[7] = '{0, 0, 0, 20'hFFFFF, 16'h0000, 16'h1234};
        vecs[8] = '{1, 0, 1, 20'h00000, 16'h0000, 16'h0012};
        lr[0] = '0;
        lr[1] = '0;
        @(negedge clk);
        check_reset_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        foreach (vecs[i]) access(vecs[i].port, vecs[i].we, vecs[i].bm, vecs[i].addr, vecs[i].wdata, vecs[i].rdata);

        // reset in the middle of a p0 write
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 1'b0, 20'h00300, 16'hAAAA);
        @(negedge clk);
        chk("pre_reset_busy", mem_we, 1'b1);
        rst_n = 1'b0;
        p0_stb = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        nacc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (p0_ack || p1_ack || mem_we) nacc++;
        end
        chk("no_ack_after_reset", nacc, 0);
        lr[0] = '0;
        lr[1] = '0;
        access(0, 1'b0, 1'b0, 20'h00100, 16'h0000, 16'hBEEF);

        // contention from a fresh reset
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b1, 1'b0, 1'b0, 20'h00100, 16'h0000);
        drive(1, 1'b1, 1'b0, 1'b0, 20'h00200, 16'h0000);
        gcnt = 0;
        nacc = 0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (p0_ack && p1_ack) nacc++;
            if ((p0_ack || p1_ack) && gcnt < 6) begin
                g[gcnt] = p1_ack;
                chk("cont_rdata", p1_ack ? p1_rdata : p0_rdata, p1_ack ? 16'h8000 : 16'hBEEF);
                gcnt++;
            end
        end
        p0_stb = 1'b0;
        p1_stb = 1'b0;
        chk("cont_count", gcnt, 6);
        chk("cont_double_ack", nacc, 0);
        for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_RR_EN
            chk("cont_grant", g[i], 1'(i % 2));
`else
            chk("cont_grant", g[i], 1'b0);
`endif
        end
        repeat (3) @(negedge clk);

        // strobe withdrawn during BUSY
        drive(0, 1'b1, 1'b0, 1'b0, 20'hFFFFF, 16'h0000);
        @(negedge clk);
        chk("drop_busy", mem_addr, 20'hFFFFF);
        p0_stb = 1'b0;
        @(negedge clk);
        chk("drop_ack", p0_ack, 1'b1);
        chk("drop_rdata", p0_rdata, 16'h1234);
        nacc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (p0_ack || p1_ack || mem_we) nacc++;
        end
        chk("drop_no_repeat", nacc, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
